dmem_arbiter: RTL and testbench

Shares the single-port synchronous data memory (14-bit word address, 32-bit data, 4-bit write-byte-enable, one-cycle read latency) between the pipeline's load/store unit (CPU port) and a word-oriented loader/debug DMA port. Issues at most one access per cycle. Formats CPU byte/half/word stores into lane-aligned data plus byte enables, and extracts and extends CPU load data. Sits between the memory stage of the three-stage pipeline and the DMEM instance.

---
 rtl/dmem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Shares one single-port synchronous DMEM between the CPU load/store unit and a word DMA port.
// Latency: request drives the RAM in its issue cycle; load data returns one cycle later.
// Backpressure: CPU wins ties, but a DMA request that has lost STARVE_LIMIT cycles is forced through.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   cpu_req_* / cpu_resp_*      byte-addressed CPU port with byte/half/word formatting
//   cpu_misaligned              registered one-cycle error pulse for a bad CPU access
//   dma_req_* / dma_resp_*      raw word-addressed DMA port
//   dmem_*                      single-port RAM, read data valid the cycle after the address
module dmem_arbiter #(
  parameter int AWIDTH       = 14,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [AWIDTH+1:0] cpu_req_addr,
  input  logic [1:0]        cpu_req_size,
  input  logic              cpu_req_unsigned,
  input  logic [31:0]       cpu_req_wdata,
  output logic              cpu_resp_valid,
  output logic [31:0]       cpu_resp_rdata,
  output logic              cpu_misaligned,
  input  logic              dma_req_valid,
  output logic              dma_req_ready,
  input  logic              dma_req_we,
  input  logic [AWIDTH-1:0] dma_req_addr,
  input  logic [3:0]        dma_req_wbe,
  input  logic [31:0]       dma_req_wdata,
  output logic              dma_resp_valid,
  output logic [31:0]       dma_resp_rdata,
  output logic [AWIDTH-1:0] dmem_addra,
  output logic [31:0]       dmem_dina,
  output logic [3:0]        dmem_wea,
  input  logic [31:0]       dmem_douta
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt;
  logic          force_dma;
  logic          cpu_issue;
  logic          dma_issue;

  logic [1:0]    off;
  logic          cpu_mis;
  logic [3:0]    cpu_fmt_wea;
  logic [31:0]   cpu_fmt_dina;

  // Response-side state captured when a CPU load issues.
  logic          cpu_resp_valid_q;
  logic          cpu_mis_q;
  logic          dma_resp_valid_q;
  logic [1:0]    lane_off_q;
  logic [1:0]    lane_size_q;
  logic          lane_uns_q;
  logic          lane_bad_q;

  logic [31:0]   lane_shifted;
  logic [31:0]   cpu_ext;

  // A DMA request that has already lost STARVE_LIMIT times takes the slot.
  assign force_dma     = dma_req_valid && (starve_cnt == LIMIT);
  assign cpu_req_ready = !rst && cpu_req_valid && !force_dma;
  assign dma_req_ready = !rst && dma_req_valid && (!cpu_req_valid || force_dma);
  assign cpu_issue     = cpu_req_ready;
  assign dma_issue     = dma_req_ready;

  assign off = cpu_req_addr[1:0];

  always_comb begin
    cpu_mis      = 1'b0;
    cpu_fmt_wea  = 4'b0000;
    cpu_fmt_dina = cpu_req_wdata;
    case (cpu_req_size)
      2'b00: begin
        cpu_fmt_wea  = 4'b0001 << off;
        cpu_fmt_dina = {4{cpu_req_wdata[7:0]}};
      end
      2'b01: begin
        cpu_mis      = off[0];
        cpu_fmt_wea  = 4'b0011 << off;
        cpu_fmt_dina = {2{cpu_req_wdata[15:0]}};
      end
      2'b10: begin
        cpu_mis      = (off != 2'b00);
        cpu_fmt_wea  = 4'b1111;
        cpu_fmt_dina = cpu_req_wdata;
      end
      default: begin
        cpu_mis      = 1'b1;
        cpu_fmt_wea  = 4'b0000;
        cpu_fmt_dina = cpu_req_wdata;
      end
    endcase
  end

  // RAM port mux; an idle cycle drives all zeros.
  always_comb begin
    dmem_addra = '0;
    dmem_dina  = '0;
    dmem_wea   = 4'b0000;
    if (cpu_issue) begin
      dmem_addra = cpu_req_addr[AWIDTH+1:2];
      dmem_dina  = cpu_fmt_dina;
      // Misaligned stores are accepted but must not touch memory.
      dmem_wea   = (cpu_req_we && !cpu_mis) ? cpu_fmt_wea : 4'b0000;
    end else if (dma_issue) begin
      dmem_addra = dma_req_addr;
      dmem_dina  = dma_req_wdata;
      dmem_wea   = dma_req_we ? dma_req_wbe : 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !dma_req_valid || dma_issue) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_resp_valid_q <= 1'b0;
      cpu_mis_q        <= 1'b0;
      dma_resp_valid_q <= 1'b0;
      lane_off_q       <= 2'b00;
      lane_size_q      <= 2'b00;
      lane_uns_q       <= 1'b0;
      lane_bad_q       <= 1'b0;
    end else begin
      cpu_resp_valid_q <= cpu_issue && !cpu_req_we;
      cpu_mis_q        <= cpu_issue && cpu_mis;
      dma_resp_valid_q <= dma_issue && !dma_req_we;
      if (cpu_issue && !cpu_req_we) begin
        lane_off_q  <= off;
        lane_size_q <= cpu_req_size;
        lane_uns_q  <= cpu_req_unsigned;
        lane_bad_q  <= cpu_mis;
      end
    end
  end

  // Bring the addressed lane down to bit 0, then extend by size.
  assign lane_shifted = dmem_douta >> {lane_off_q, 3'b000};

  always_comb begin
    cpu_ext = dmem_douta;
    case (lane_size_q)
      2'b00:   cpu_ext = {{24{lane_shifted[7] & ~lane_uns_q}}, lane_shifted[7:0]};
      2'b01:   cpu_ext = {{16{lane_shifted[15] & ~lane_uns_q}}, lane_shifted[15:0]};
      default: cpu_ext = dmem_douta;
    endcase
  end

  assign cpu_resp_valid = cpu_resp_valid_q;
  assign cpu_misaligned = cpu_mis_q;
  assign cpu_resp_rdata = (cpu_resp_valid_q && !lane_bad_q) ? cpu_ext : 32'h0;
  assign dma_resp_valid = dma_resp_valid_q;
  assign dma_resp_rdata = dma_resp_valid_q ? dmem_douta : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int AW    = 14;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req_valid, cpu_req_ready, cpu_req_we, cpu_req_unsigned;
  logic [AW+1:0] cpu_req_addr;
  logic [1:0]    cpu_req_size;
  logic [31:0]   cpu_req_wdata;
  logic          cpu_resp_valid, cpu_misaligned;
  logic [31:0]   cpu_resp_rdata;
  logic          dma_req_valid, dma_req_ready, dma_req_we;
  logic [AW-1:0] dma_req_addr;
  logic [3:0]    dma_req_wbe;
  logic [31:0]   dma_req_wdata;
  logic          dma_resp_valid;
  logic [31:0]   dma_resp_rdata;
  logic [AW-1:0] dmem_addra;
  logic [31:0]   dmem_dina;
  logic [3:0]    dmem_wea;
  logic [31:0]   dmem_douta;

  int passed = 0;
  int total  = 0;

  logic [31:0] ram     [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  dmem_arbiter #(.AWIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr),
    .cpu_req_size(cpu_req_size), .cpu_req_unsigned(cpu_req_unsigned),
    .cpu_req_wdata(cpu_req_wdata), .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_rdata(cpu_resp_rdata), .cpu_misaligned(cpu_misaligned),
    .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
    .dma_req_we(dma_req_we), .dma_req_addr(dma_req_addr),
    .dma_req_wbe(dma_req_wbe), .dma_req_wdata(dma_req_wdata),
    .dma_resp_valid(dma_resp_valid), .dma_resp_rdata(dma_resp_rdata),
    .dmem_addra(dmem_addra), .dmem_dina(dmem_dina),
    .dmem_wea(dmem_wea), .dmem_douta(dmem_douta)
  );

  // Behavioural single-port RAM, read-first, one-cycle read latency.
  always @(posedge clk) begin
    if (dmem_wea[0]) ram[dmem_addra][7:0]   <= dmem_dina[7:0];
    if (dmem_wea[1]) ram[dmem_addra][15:8]  <= dmem_dina[15:8];
    if (dmem_wea[2]) ram[dmem_addra][23:16] <= dmem_dina[23:16];
    if (dmem_wea[3]) ram[dmem_addra][31:24] <= dmem_dina[31:24];
    dmem_douta <= ram[dmem_addra];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cpu(input logic v, input logic we, input logic [AW+1:0] a,
                           input logic [1:0] sz, input logic uns, input logic [31:0] d);
    cpu_req_valid = v; cpu_req_we = we; cpu_req_addr = a;
    cpu_req_size = sz; cpu_req_unsigned = uns; cpu_req_wdata = d;
  endtask

  task automatic drive_dma(input logic v, input logic we, input logic [AW-1:0] a,
                           input logic [3:0] wbe, input logic [31:0] d);
    dma_req_valid = v; dma_req_we = we; dma_req_addr = a;
    dma_req_wbe = wbe; dma_req_wdata = d;
  endtask

  task automatic idle;
    drive_cpu(0, 0, '0, 2'b00, 0, 32'h0);
    drive_dma(0, 0, '0, 4'h0, 32'h0);
  endtask

  // Reference: value a CPU load returns from a stored word.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input int off,
                                           input int size, input bit uns);
    logic [31:0] r;
    r = w >> (8 * off);
    if (size == 0) begin
      r = r & 32'd255;
      if (!uns && r >= 32'd128) r = r - 32'd256;
    end else if (size == 1) begin
      r = r & 32'd65535;
      if (!uns && r >= 32'd32768) r = r - 32'd65536;
    end else begin
      r = w;
    end
    return r;
  endfunction

  function automatic bit ref_bad(input int off, input int size);
    return (size == 3) || (size == 1 && off % 2 == 1) || (size == 2 && off != 0);
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    drive_cpu(1, 1, 16'h0010, 2'b10, 0, 32'h12345678);
    drive_dma(1, 1, 14'd3, 4'hF, 32'h87654321);
    tick; tick;
    total++; if (cpu_req_ready !== 1'b0) $display("FAIL rst_cpu_ready got %0b want 0", cpu_req_ready); else passed++;
    total++; if (dma_req_ready !== 1'b0) $display("FAIL rst_dma_ready got %0b want 0", dma_req_ready); else passed++;
    total++; if (dmem_wea !== 4'h0) $display("FAIL rst_wea got %h want 0", dmem_wea); else passed++;
    total++; if ({cpu_resp_valid, dma_resp_valid, cpu_misaligned} !== 3'b000)
      $display("FAIL rst_regs got %b want 000", {cpu_resp_valid, dma_resp_valid, cpu_misaligned}); else passed++;
    idle;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_store_load_word;
    drive_cpu(1, 1, 16'h0010, 2'b10, 0, 32'hDEADBEEF);
    #1;
    total++; if (cpu_req_ready !== 1'b1) $display("FAIL sw_ready got %0b want 1", cpu_req_ready); else passed++;
    total++; if (dmem_wea !== 4'b1111 || dmem_dina !== 32'hDEADBEEF || dmem_addra !== 14'd4)
      $display("FAIL sw_ram got wea=%b dina=%h addr=%0d want 1111 deadbeef 4", dmem_wea, dmem_dina, dmem_addra); else passed++;
    tick;
    drive_cpu(1, 0, 16'h0010, 2'b10, 0, 32'h0);
    tick;
    idle;
    #1;
    total++; if (cpu_resp_valid !== 1'b1 || cpu_resp_rdata !== 32'hDEADBEEF)
      $display("FAIL lw_resp got v=%0b d=%h want 1 deadbeef", cpu_resp_valid, cpu_resp_rdata); else passed++;
    tick;
  endtask

  task automatic test_byte;
    drive_cpu(1, 1, 16'h0013, 2'b00, 0, 32'h12345680);
    #1;
    total++; if (dmem_wea !== 4'b1000 || dmem_dina !== 32'h80808080)
      $display("FAIL sb_ram got wea=%b dina=%h want 1000 80808080", dmem_wea, dmem_dina); else passed++;
    tick;
    drive_cpu(1, 0, 16'h0013, 2'b00, 0, 32'h0);
    tick;
    drive_cpu(1, 0, 16'h0013, 2'b00, 1, 32'h0);
    #1;
    total++; if (cpu_resp_valid !== 1'b1 || cpu_resp_rdata !== 32'hFFFFFF80)
      $display("FAIL lb_resp got v=%0b d=%h want 1 ffffff80", cpu_resp_valid, cpu_resp_rdata); else passed++;
    tick;
    idle;
    #1;
    total++; if (cpu_resp_valid !== 1'b1 || cpu_resp_rdata !== 32'h00000080)
      $display("FAIL lbu_resp got v=%0b d=%h want 1 00000080", cpu_resp_valid, cpu_resp_rdata); else passed++;
    tick;
  endtask

  task automatic test_misaligned;
    drive_cpu(1, 1, 16'h0020, 2'b10, 0, 32'hA5A5A5A5);
    tick;
    drive_cpu(1, 0, 16'h0011, 2'b01, 0, 32'h0);
    #1;
    total++; if (cpu_req_ready !== 1'b1 || dmem_wea !== 4'h0)
      $display("FAIL lh_mis_issue got rdy=%0b wea=%b want 1 0000", cpu_req_ready, dmem_wea); else passed++;
    tick;
    drive_cpu(1, 1, 16'h0022, 2'b10, 0, 32'h55555555);
    #1;
    total++; if (cpu_req_ready !== 1'b1 || dmem_wea !== 4'h0)
      $display("FAIL sw_mis_issue got rdy=%0b wea=%b want 1 0000", cpu_req_ready, dmem_wea); else passed++;
    total++; if (cpu_misaligned !== 1'b1 || cpu_resp_valid !== 1'b1 || cpu_resp_rdata !== 32'h0)
      $display("FAIL lh_mis_resp got mis=%0b v=%0b d=%h want 1 1 0", cpu_misaligned, cpu_resp_valid, cpu_resp_rdata); else passed++;
    tick;
    drive_cpu(1, 0, 16'h0020, 2'b10, 0, 32'h0);
    #1;
    total++; if (cpu_misaligned !== 1'b1 || cpu_resp_valid !== 1'b0)
      $display("FAIL sw_mis_resp got mis=%0b v=%0b want 1 0", cpu_misaligned, cpu_resp_valid); else passed++;
    tick;
    idle;
    #1;
    total++; if (cpu_misaligned !== 1'b0 || cpu_resp_rdata !== 32'hA5A5A5A5)
      $display("FAIL mis_mem_unchanged got mis=%0b d=%h want 0 a5a5a5a5", cpu_misaligned, cpu_resp_rdata); else passed++;
    tick;
  endtask

  task automatic test_dma_wbe;
    drive_dma(1, 1, 14'd5, 4'b1111, 32'hFFFFFFFF);
    tick;
    drive_dma(1, 1, 14'd5, 4'b0101, 32'h11223344);
    #1;
    total++; if (dma_req_ready !== 1'b1 || dmem_wea !== 4'b0101 || dmem_addra !== 14'd5)
      $display("FAIL dma_wr got rdy=%0b wea=%b addr=%0d want 1 0101 5", dma_req_ready, dmem_wea, dmem_addra); else passed++;
    tick;
    drive_dma(1, 0, 14'd5, 4'b1111, 32'h0);
    tick;
    idle;
    #1;
    total++; if (dma_resp_valid !== 1'b1 || dma_resp_rdata !== 32'hFF22FF44 || cpu_resp_valid !== 1'b0)
      $display("FAIL dma_rd got v=%0b d=%h cpu_v=%0b want 1 ff22ff44 0", dma_resp_valid, dma_resp_rdata, cpu_resp_valid); else passed++;
    tick;
  endtask

  task automatic test_starve;
    bit pc, pd, gd;
    pc = 0; pd = 0;
    for (int i = 0; i < 15; i++) begin
      drive_cpu(1, 0, 16'h0010, 2'b10, 0, 32'h0);
      drive_dma(1, 0, 14'd4, 4'h0, 32'h0);
      #1;
      gd = (i % (LIMIT + 1) == LIMIT);
      total++; if (cpu_req_ready !== !gd || dma_req_ready !== gd)
        $display("FAIL starve_grant cyc %0d got cpu=%0b dma=%0b want %0b %0b", i, cpu_req_ready, dma_req_ready, !gd, gd); else passed++;
      total++; if (cpu_resp_valid !== pc || dma_resp_valid !== pd)
        $display("FAIL starve_resp cyc %0d got cpu_v=%0b dma_v=%0b want %0b %0b", i, cpu_resp_valid, dma_resp_valid, pc, pd); else passed++;
      if (pd) begin
        total++; if (dma_resp_rdata !== 32'h80ADBEEF)
          $display("FAIL starve_dma_data got %h want 80adbeef", dma_resp_rdata); else passed++;
      end
      pc = !gd; pd = gd;
      tick;
    end
    idle;
    #1;
    total++; if (cpu_resp_valid !== 1'b0 || dma_resp_valid !== 1'b1 || dma_resp_rdata !== 32'h80ADBEEF)
      $display("FAIL starve_last got cpu_v=%0b dma_v=%0b d=%h want 0 1 80adbeef", cpu_resp_valid, dma_resp_valid, dma_resp_rdata); else passed++;
    tick;
  endtask

  task automatic test_reset_inflight;
    drive_cpu(1, 0, 16'h0010, 2'b10, 0, 32'h0);
    tick;
    rst = 1'b1;
    drive_dma(1, 1, 14'd4, 4'hF, 32'h0);
    drive_cpu(1, 1, 16'h0010, 2'b10, 0, 32'h0);
    #1;
    total++; if (cpu_req_ready !== 1'b0 || dma_req_ready !== 1'b0 || dmem_wea !== 4'h0)
      $display("FAIL rst1_issue got cpu=%0b dma=%0b wea=%b want 0 0 0", cpu_req_ready, dma_req_ready, dmem_wea); else passed++;
    total++; if (cpu_resp_valid !== 1'b1 || cpu_resp_rdata !== 32'h80ADBEEF)
      $display("FAIL rst_inflight got v=%0b d=%h want 1 80adbeef", cpu_resp_valid, cpu_resp_rdata); else passed++;
    tick;
    total++; if (cpu_resp_valid !== 1'b0 || cpu_req_ready !== 1'b0 || dma_req_ready !== 1'b0)
      $display("FAIL rst2 got v=%0b cpu=%0b dma=%0b want 0 0 0", cpu_resp_valid, cpu_req_ready, dma_req_ready); else passed++;
    tick;
    rst = 1'b0;
    idle;
    #1;
    total++; if ({cpu_resp_valid, dma_resp_valid, cpu_misaligned, dmem_wea} !== 7'h0 ||
                 cpu_resp_rdata !== 32'h0 || dma_resp_rdata !== 32'h0 || dmem_addra !== '0 || dmem_dina !== 32'h0)
      $display("FAIL post_rst_outputs not all zero got v=%0b%0b mis=%0b wea=%b", cpu_resp_valid, dma_resp_valid, cpu_misaligned, dmem_wea); else passed++;
    tick;
    // Starvation counter must restart from zero: DMA wins on the fifth contended cycle.
    for (int i = 0; i <= LIMIT; i++) begin
      drive_cpu(1, 0, 16'h0010, 2'b10, 0, 32'h0);
      drive_dma(1, 0, 14'd4, 4'h0, 32'h0);
      #1;
      total++; if (dma_req_ready !== (i == LIMIT))
        $display("FAIL post_rst_starve cyc %0d got dma=%0b want %0b", i, dma_req_ready, (i == LIMIT)); else passed++;
      tick;
    end
    idle;
    tick;
  endtask

  task automatic test_random;
    int lost;
    bit cv, cw, cu, dv, dw, gc, gd, bad;
    int off, sz;
    logic [AW+1:0] ca;
    logic [AW-1:0] da, cwa;
    logic [3:0] wbe, ew;
    logic [31:0] cd, dd;
    bit pc, pd, pm;
    logic [31:0] pcd, pdd;
    // Seed the working region so every read returns known data.
    for (int w = 16; w < 24; w++) begin
      dd = $urandom;
      ref_mem[w] = dd;
      drive_dma(1, 1, AW'(w), 4'hF, dd);
      tick;
    end
    idle;
    tick;
    lost = 0; pc = 0; pd = 0; pm = 0; pcd = 0; pdd = 0;
    for (int n = 0; n < 400; n++) begin
      cv = ($urandom_range(0, 9) < 7); cw = $urandom_range(0, 1); cu = $urandom_range(0, 1);
      ca = 16'(64 + $urandom_range(0, 31)); sz = $urandom_range(0, 3); cd = $urandom;
      dv = ($urandom_range(0, 1) == 1); dw = $urandom_range(0, 1);
      da = AW'(16 + $urandom_range(0, 7)); wbe = 4'($urandom_range(0, 15)); dd = $urandom;
      drive_cpu(cv, cw, ca, 2'(sz), cu, cd);
      drive_dma(dv, dw, da, wbe, dd);
      off = int'(ca % 4); cwa = AW'(ca / 4); bad = ref_bad(off, sz);
      gd = dv && (!cv || lost == LIMIT);
      gc = cv && !gd;
      lost = (dv && !gd) ? ((lost < LIMIT) ? lost + 1 : LIMIT) : 0;
      ew = 4'h0;
      if (gc && cw && !bad) ew = (sz == 0) ? 4'(1 << off) : (sz == 1) ? 4'(3 << off) : 4'hF;
      if (gd && dw) ew = wbe;
      #1;
      total++; if (cpu_req_ready !== gc || dma_req_ready !== gd)
        $display("FAIL rnd_grant n=%0d got cpu=%0b dma=%0b want %0b %0b", n, cpu_req_ready, dma_req_ready, gc, gd); else passed++;
      total++; if (dmem_wea !== ew)
        $display("FAIL rnd_wea n=%0d got %b want %b", n, dmem_wea, ew); else passed++;
      total++; if (cpu_resp_valid !== pc || cpu_misaligned !== pm || (pc && cpu_resp_rdata !== pcd))
        $display("FAIL rnd_cpu_resp n=%0d got v=%0b mis=%0b d=%h want %0b %0b %h", n, cpu_resp_valid, cpu_misaligned, cpu_resp_rdata, pc, pm, pcd); else passed++;
      total++; if (dma_resp_valid !== pd || (pd && dma_resp_rdata !== pdd))
        $display("FAIL rnd_dma_resp n=%0d got v=%0b d=%h want %0b %h", n, dma_resp_valid, dma_resp_rdata, pd, pdd); else passed++;
      pc = gc && !cw; pm = gc && bad; pd = gd && !dw;
      pcd = bad ? 32'h0 : ref_load(ref_mem[cwa], off, sz, cu);
      pdd = ref_mem[da];
      if (gc && cw && !bad) begin
        if (sz == 0) ref_mem[cwa][8*off +: 8] = cd[7:0];
        else if (sz == 1) ref_mem[cwa][8*off +: 16] = cd[15:0];
        else ref_mem[cwa] = cd;
      end
      if (gd && dw)
        for (int b = 0; b < 4; b++) if (wbe[b]) ref_mem[da][8*b +: 8] = dd[8*b +: 8];
      tick;
    end
    idle;
    #1;
    total++; if (cpu_resp_valid !== pc || (pc && cpu_resp_rdata !== pcd) || dma_resp_valid !== pd || (pd && dma_resp_rdata !== pdd))
      $display("FAIL rnd_final got cpu_v=%0b dma_v=%0b want %0b %0b", cpu_resp_valid, dma_resp_valid, pc, pd); else passed++;
    tick;
  endtask

  initial begin
    rst = 1'b1;
    idle;
    test_reset;
    test_store_load_word;
    test_byte;
    test_misaligned;
    test_dma_wbe;
    test_starve;
    test_reset_inflight;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
